// File: rtl/scan_pkg.sv
// Shared scan-port definitions: frame FSM states, counter sizing, scanner-facing widths.
package scan_pkg;

  localparam int unsigned SCAN_CHAIN_LEN_DEFAULT = 64;
  localparam int unsigned SCAN_WORD_W            = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2
  } frame_state_e;

  // Counter must represent 0..CHAIN_LEN plus at least one overrun value.
  function automatic int unsigned shift_cnt_width(input int unsigned chain_len);
    return $clog2(chain_len + 2);
  endfunction

endpackage

// File: rtl/scan_frame_counter.sv
// Frame tracker for the scan port: FSM, saturating shift counter, frame result pulses.
// Optional running parity of shifted-in bits when SCAN_PARITY_EN is defined.
module scan_frame_counter
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic scan_enable,
  input  logic scan_ck_enable,
  input  logic scan_input,
  output logic frame_done,
  output logic frame_err,
  output logic frame_parity
);

  localparam int unsigned      CNT_W    = shift_cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d, err_d;
  logic             shift_strobe;

  assign shift_strobe = scan_enable & scan_ck_enable;

  // Next state, counter update and END-state frame result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (shift_strobe && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (scan_enable) begin
          state_d = SHIFT;
          cnt_d   = shift_strobe ? CNT_W'(1) : '0;
        end
      end
      SHIFT: begin
        if (!scan_enable) begin
          state_d = END;
        end
      end
      END: begin
        state_d = IDLE;
        done_d  = (cnt_q == CNT_FULL);
        err_d   = (cnt_q != '0) && (cnt_q != CNT_FULL);
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and result pulse registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

`ifdef SCAN_PARITY_EN
  logic par_q, par_d, frame_parity_d;

  // Running parity restarts on frame entry; published only on a good frame.
  always_comb begin
    par_d          = par_q;
    frame_parity_d = frame_parity;
    if ((state_q == IDLE) && scan_enable) begin
      par_d = shift_strobe & scan_input;
    end else if (shift_strobe) begin
      par_d = par_q ^ scan_input;
    end
    if (done_d) begin
      frame_parity_d = par_q;
    end
  end

  // Parity registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      par_q        <= 1'b0;
      frame_parity <= 1'b0;
    end else begin
      par_q        <= par_d;
      frame_parity <= frame_parity_d;
    end
  end
`else
  logic unused_scan_input;
  assign unused_scan_input = scan_input;
  assign frame_parity      = 1'b0;
`endif

endmodule

// File: rtl/scan_chain_responder.sv
// Target-side scan chain endpoint: shift/capture/hold chain plus frame tracking.
// Build option: SCAN_PARITY_EN enables frame_parity reporting.
module scan_chain_responder
  import scan_pkg::*;
#(
  parameter int unsigned           CHAIN_LEN = SCAN_CHAIN_LEN_DEFAULT,
  parameter logic [CHAIN_LEN-1:0]  RESET_VAL = '0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 scan_enable,
  input  logic                 scan_ck_enable,
  input  logic                 scan_input,
  output logic                 scan_output,
  input  logic [CHAIN_LEN-1:0] func_d,
  output logic [CHAIN_LEN-1:0] func_q,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 frame_parity
);

  logic [CHAIN_LEN-1:0] chain_q;

  // Chain register: shift in scan mode, capture functional state otherwise, gated by strobe.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chain_q <= RESET_VAL;
    end else if (scan_ck_enable) begin
      if (scan_enable) begin
        chain_q <= {chain_q[CHAIN_LEN-2:0], scan_input};
      end else begin
        chain_q <= func_d;
      end
    end
  end

  assign scan_output = chain_q[CHAIN_LEN-1];
  assign func_q      = chain_q;

  scan_frame_counter #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_frame_counter (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .scan_enable    (scan_enable),
    .scan_ck_enable (scan_ck_enable),
    .scan_input     (scan_input),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frame_parity   (frame_parity)
  );

endmodule

// File: tb/tb_scan_chain_responder.sv
// Bench for scan_chain_responder (CHAIN_LEN=8, RESET_VAL=8'hA5): directed plan steps plus random traffic.
module tb_scan_chain_responder;

  localparam logic [7:0] RST = 8'hA5;
`ifdef SCAN_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       aclk, aresetn;
  logic       scan_enable, scan_ck_enable, scan_input, scan_output;
  logic [7:0] func_d, func_q;
  logic       frame_done, frame_err, frame_parity;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: chain contents and frame bookkeeping as counts and flags.
  logic [7:0] m_chain;
  bit m_open, m_cool;
  int m_cnt;
  bit m_par, m_done, m_err, m_fpar;
  bit n_done, n_err, n_pv, n_par;

  scan_chain_responder #(
    .CHAIN_LEN (8),
    .RESET_VAL (RST)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .scan_enable    (scan_enable),
    .scan_ck_enable (scan_ck_enable),
    .scan_input     (scan_input),
    .scan_output    (scan_output),
    .func_d         (func_d),
    .func_q         (func_q),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .frame_parity   (frame_parity)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("func_q",       64'(func_q),       64'(m_chain));
    chk("scan_output",  64'(scan_output),  64'(m_chain[7]));
    chk("frame_done",   64'(frame_done),   64'(m_done));
    chk("frame_err",    64'(frame_err),    64'(m_err));
    chk("frame_parity", 64'(frame_parity), 64'(m_fpar));
  endtask

  task automatic model_reset();
    m_chain = RST;
    m_open = 0; m_cool = 0; m_cnt = 0; m_par = 0;
    m_done = 0; m_err = 0; m_fpar = 0;
    n_done = 0; n_err = 0; n_pv = 0; n_par = 0;
  endtask

  // One clock: drive inputs, advance model, check all outputs 1 time unit after the edge.
  task automatic step(input logic se, input logic ce, input logic si, input logic [7:0] fd);
    bit blocked;
    scan_enable = se; scan_ck_enable = ce; scan_input = si; func_d = fd;
    @(posedge aclk);
    m_done = n_done; m_err = n_err;
    if (n_pv) m_fpar = n_par;
    n_done = 0; n_err = 0; n_pv = 0;
    blocked = m_cool;
    m_cool  = 0;
    if (m_open) begin
      if (se) begin
        if (ce) begin m_cnt++; m_par ^= si; end
      end else begin
        m_open = 0; m_cool = 1;
        n_done = (m_cnt == 8);
        n_err  = (m_cnt != 0) && (m_cnt != 8);
        n_pv   = n_done && PAR_EN;
        n_par  = m_par;
      end
    end else if (se && !blocked) begin
      m_open = 1; m_cnt = ce ? 1 : 0; m_par = ce & si;
    end
    if (ce) m_chain = se ? {m_chain[6:0], si} : fd;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  // Shift n bits (MSB of the n-bit field first), close the frame, check the result pulse.
  task automatic frame(input int n, input logic [15:0] bits, input bit exp_done, input bit exp_err,
                       input bit exp_par);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    chk("pulse_early", 64'({frame_done, frame_err}), 64'(0));
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    chk("frame_done_at2", 64'(frame_done), 64'(exp_done));
    chk("frame_err_at2",  64'(frame_err),  64'(exp_err));
    if (exp_done) chk("frame_parity_at2", 64'(frame_parity), 64'(exp_par));
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    chk("pulse_one_cycle", 64'({frame_done, frame_err}), 64'(0));
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_func_q", 64'(func_q), 64'(RST));
    aresetn = 1'b1;
  endtask

  logic [7:0] exp_out;
  logic [7:0] pat;
  bit         se_r;

  initial begin
    aresetn = 1'b0; scan_enable = 0; scan_ck_enable = 0; scan_input = 0; func_d = '0;
    model_reset();
    #12;
    check_all();
    chk("reset_func_q", 64'(func_q), 64'(RST));
    chk("reset_scan_output", 64'(scan_output), 64'(1));
    aresetn = 1'b1;

    // Readout of RESET_VAL through scan_output while shifting zeros.
    exp_out = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk("readout_bit", 64'(scan_output), 64'(exp_out[7-i]));
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
    end
    chk("readout_empty", 64'(func_q), 64'(0));
    idle(3);

    // Shift-through and parity frames.
    pat = 8'b10110010;
    frame(8, {8'h00, pat}, 1'b1, 1'b0, 1'b0);
    chk("shift_through", 64'(func_q), 64'(8'b10110010));
    frame(8, 16'h00B3, 1'b1, 1'b0, PAR_EN);
    chk("shift_through2", 64'(func_q), 64'(8'b10110011));

    // Short, long and empty frames.
    frame(5, 16'h0015, 1'b0, 1'b1, 1'b0);
    frame(12, 16'h0ABC, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
    idle(2);
    chk("empty_no_pulse", 64'({frame_done, frame_err}), 64'(0));
    idle(1);

    // Capture then hold.
    step(1'b0, 1'b1, 1'b0, 8'h3C);
    chk("capture", 64'(func_q), 64'(8'h3C));
    for (int i = 0; i < 10; i++) step(1'(~i[0]), 1'b0, 1'($urandom), 8'($urandom));
    chk("capture_hold", 64'(func_q), 64'(8'h3C));
    idle(3);

    // Reset mid-frame, then re-enter with scan_enable held high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'($urandom), 8'($urandom));
    scan_enable = 1'b1;
    pulse_reset();
    frame(8, 16'h005A, 1'b1, 1'b0, 1'b0);

    // scan_enable rising during END: shift in END is not counted toward the new frame.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'($urandom), 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'($urandom));
    chk("reenter_first_done", 64'(frame_done), 64'(1));
    frame(8, 16'h00C3, 1'b1, 1'b0, 1'b0);

    // Random traffic with long enable runs and rare resets.
    se_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) se_r = ~se_r;
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step(se_r, 1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_chain_responder.md
# scan_chain_responder

Synthesizable target-side endpoint for the scan-chain port driven by the scanner block. It holds a CHAIN_LEN-bit state register and shifts one bit per gated clock while in scan mode. Outside scan mode it captures functional next-state, and it reports frame completion or framing errors. The block is used as the DUT stand-in for scanner bring-up and as a reusable wrapper around small user IPs whose state is snapshotted and restored.

## Interface
Parameters:
- CHAIN_LEN, default 64: number of scan flops. Legal range is 2..4096.
- RESET_VAL, default 0: chain contents after reset, CHAIN_LEN bits.

Ports:
- aclk, in, 1: sole clock. One clock; reset is asynchronous and active-low.
- aresetn, in, 1: asynchronous active-low reset.
- scan_enable, in, 1: 1 selects shift mode, 0 selects functional capture.
- scan_ck_enable, in, 1: gated-clock strobe. The chain advances only on cycles where this is 1.
- scan_input, in, 1: serial data in from the scanner.
- scan_output, out, 1: serial data out to the scanner.
- func_d, in, CHAIN_LEN: functional next-state from the wrapped logic.
- func_q, out, CHAIN_LEN: current chain contents, fed to the wrapped logic.
- frame_done, out, 1: one-cycle pulse when a complete frame ends.
- frame_err, out, 1: one-cycle pulse when a frame ends with the wrong length.
- frame_parity, out, 1: XOR of the bits shifted in during the last completed frame.

## Operation
- Shift: on a cycle with scan_enable=1 and scan_ck_enable=1:
  - chain <= {chain[CHAIN_LEN-2:0], scan_input}.
  - shift_cnt increments, saturating at its all-ones value. Its width is $clog2(CHAIN_LEN+2).
- Capture: on a cycle with scan_enable=0 and scan_ck_enable=1, chain <= func_d. shift_cnt is unaffected.
- Hold: on a cycle with scan_ck_enable=0, chain and shift_cnt hold.
- scan_output is chain[CHAIN_LEN-1], taken directly from the flop. func_q is chain.
- Frame FSM states: IDLE, SHIFT, END.
  - IDLE→SHIFT when scan_enable=1. On entry, shift_cnt is cleared to 0, or to 1 if a shift happens in the same cycle.
  - SHIFT→END when scan_enable=0.
  - END→IDLE unconditionally after one cycle.
- Frame result, evaluated in END:
  - shift_cnt == CHAIN_LEN: frame_done=1.
  - shift_cnt == 0: neither pulse fires (empty enable window).
  - Any other value, including saturated overrun: frame_err=1.
- If scan_enable rises again while in END, the FSM goes to IDLE first. The new frame is entered on the next cycle, and no shift is lost because the chain shifts independently of the FSM.

## Timing
- Reset values:
  - chain = RESET_VAL, so scan_output = RESET_VAL[CHAIN_LEN-1] and func_q = RESET_VAL.
  - frame_done = 0, frame_err = 0, frame_parity = 0.
  - FSM in IDLE, shift_cnt = 0.
- Shift latency: scan_output reflects a shift on the cycle after the strobe. A bit entering at scan_input appears on scan_output CHAIN_LEN strobes later.
- frame_done and frame_err assert exactly 2 cycles after the first cycle with scan_enable=0 (one cycle into END, registered). Each is high for exactly 1 cycle, and they are mutually exclusive.
- A shift strobe on the same cycle scan_enable falls performs a capture, not a shift. Mode is sampled per cycle.
- Reset asserted mid-frame:
  - Chain reloads RESET_VAL immediately.
  - No done or error pulse is generated.
  - The FSM resumes in IDLE after deassertion even if scan_enable is held high. The next cycle enters SHIFT.

## Configuration
- SCAN_PARITY_EN:
  - Defined: a running parity flop is cleared on IDLE→SHIFT and XORs scan_input on every shift. It is copied to frame_parity when frame_done fires, and held otherwise.
  - Undefined: frame_parity is tied to 0 and the parity flop is not instantiated.

## Structure
- Package scan_pkg holds:
  - The frame FSM state enum (IDLE, SHIFT, END).
  - The function computing the counter width.
  - Localparams shared with the scanner: default chain length 64 and scan word width 32.
- One natural sub-module is scan_frame_counter. It contains the FSM, shift_cnt, the result comparison and the optional parity.
- The chain register stays in the top module.

## Test plan
- Shift-through, CHAIN_LEN=8, RESET_VAL=0:
  - Stimulus: 8 strobes with scan_enable=1, scan_input pattern 1,0,1,1,0,0,1,0, then drop scan_enable.
  - Required: func_q=8'b10110010 and frame_done high exactly 2 cycles after the fall.
- Readout, RESET_VAL=8'hA5: 8 strobes with scan_input=0 give scan_output bits 1,0,1,0,0,1,0,1 and then chain=0.
- Short and long frames:
  - 5 strobes give frame_err=1 and frame_done=0.
  - 12 strobes give frame_err=1.
  - Enable with 0 strobes gives no pulse.
- Capture: with scan_enable=0, func_d=8'h3C and one strobe, func_q=8'h3C the next cycle. With scan_ck_enable=0 for 10 cycles, there is no change.
- Reset mid-frame: after 3 strobes, pulse aresetn low. Required: func_q=RESET_VAL, no pulse, and a following full 8-strobe frame gives frame_done.
- SCAN_PARITY_EN: frame 8'b10110010 gives frame_parity=0, frame 8'b10110011 gives 1. Without the macro, frame_parity stays 0.
